// File: rtl/param_table_sequencer.sv
// Purpose: streams a contiguous, wrapping run of constant table entries and sums the accepted beats.
// Latency: the first beat is presented one cycle after start; done pulses the cycle after the final handshake.
// Backpressure: valid/ready; out_data/out_index/out_last hold while out_valid && !out_ready.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start, start_idx, count  command: first table index and number of beats (sampled only in IDLE)
//   abort                    cancels a run in STREAM or DONE; beats already accepted stay in sum
//   busy, err, done          status: run active, command rejected (pulse), run completed (pulse)
//   out_valid/ready/data/index/last  beat stream, all outputs registered
//   sum                      running sum of accepted beats, modulo 2^WIDTH
module param_table_sequencer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] TABLE [DEPTH] = '{121, 110, 2, 20},
    parameter int LEN_W = 8,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] start_idx,
    input  logic [LEN_W-1:0] count,
    input  logic             abort,
    output logic             busy,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             done,
    output logic [WIDTH-1:0] sum
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    // One extra bit so the range check also works when DEPTH is a power of two.
    localparam logic [IDX_W:0]   DEPTH_LIM = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] rem, rem_nxt;
    logic             busy_nxt, err_nxt, valid_nxt, last_nxt, done_nxt;
    logic [WIDTH-1:0] data_nxt, sum_nxt;
    logic [IDX_W-1:0] idx_nxt, ptr_inc;

    // out_index doubles as the table pointer while streaming.
    always_comb begin
        ptr_inc = (out_index == LAST_IDX) ? '0 : out_index + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            busy      <= busy_nxt;
            err       <= err_nxt;
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            out_index <= idx_nxt;
            out_last  <= last_nxt;
            done      <= done_nxt;
            sum       <= sum_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        busy_nxt  = busy;
        err_nxt   = 1'b0;
        valid_nxt = out_valid;
        data_nxt  = out_data;
        idx_nxt   = out_index;
        last_nxt  = out_last;
        done_nxt  = 1'b0;
        sum_nxt   = sum;

        case (state)
            IDLE: begin
                // abort alongside start drops the command.
                if (start && !abort) begin
                    if ({1'b0, start_idx} >= DEPTH_LIM) begin
                        err_nxt = 1'b1;
                    end else if (count == '0) begin
                        sum_nxt   = '0;
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        sum_nxt   = '0;
                        busy_nxt  = 1'b1;
                        rem_nxt   = count;
                        valid_nxt = 1'b1;
                        idx_nxt   = start_idx;
                        data_nxt  = TABLE[start_idx];
                        last_nxt  = (count == LEN_W'(1));
                        state_nxt = STREAM;
                    end
                end
            end

            STREAM: begin
                // The beat is counted even when abort arrives on the same edge.
                if (out_valid && out_ready) begin
                    sum_nxt = sum + out_data;
                    if (rem == LEN_W'(1)) begin
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        data_nxt  = '0;
                        idx_nxt   = '0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        rem_nxt  = rem - LEN_W'(1);
                        idx_nxt  = ptr_inc;
                        data_nxt = TABLE[ptr_inc];
                        last_nxt = (rem == LEN_W'(2));
                    end
                end
                if (abort) begin
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    data_nxt  = '0;
                    idx_nxt   = '0;
                    done_nxt  = 1'b0;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end

            DONE: begin
                // done was raised on entry; start here is ignored.
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_param_table_sequencer.sv
module tb_param_table_sequencer;

    localparam int DEPTH = 4;
    localparam int TBL [DEPTH] = '{121, 110, 2, 20};

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready;
    logic [1:0]  start_idx;
    logic [7:0]  count;
    logic        busy, err, out_valid, out_last, done;
    logic [31:0] out_data, sum;
    logic [1:0]  out_index;

    int n_checks = 0;
    int n_pass   = 0;

    // Results of the most recent command, gathered by drive_cmd.
    int q_data[$];
    int q_idx[$];
    bit q_last[$];
    int first_valid, done_cyc, done_cnt, idle_cyc;
    bit timed_out;

    always #5 clk = ~clk;

    param_table_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_idx (start_idx),
        .count     (count),
        .abort     (abort),
        .busy      (busy),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .done      (done),
        .sum       (sum)
    );

    // Reference: beat k of a run starting at idx is table entry (idx+k) mod DEPTH.
    function automatic int model_data(int idx, int k);
        return TBL[(idx + k) % DEPTH];
    endfunction

    function automatic int model_index(int idx, int k);
        return (idx + k) % DEPTH;
    endfunction

    function automatic logic [31:0] model_sum(int idx, int n);
        logic [31:0] s = 32'd0;
        for (int k = 0; k < n; k++) s += 32'(model_data(idx, k));
        return s;
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and plays consumer until busy drops. Cycle 1 is the
    // first cycle after the start edge. abort_after >= 0 raises abort once that
    // many beats have been accepted, with out_ready forced to abort_ready.
    task automatic drive_cmd(input int idx, input int cnt, input int ready_pct,
                             input int abort_after, input bit abort_ready);
        q_data.delete();
        q_idx.delete();
        q_last.delete();
        first_valid = -1;
        done_cyc    = -1;
        done_cnt    = 0;
        idle_cyc    = -1;
        timed_out   = 1'b1;
        start     = 1'b1;
        start_idx = 2'(idx);
        count     = 8'(cnt);
        step();
        start = 1'b0;
        for (int c = 1; c < 400; c++) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (!busy) begin
                idle_cyc  = c;
                timed_out = 1'b0;
                break;
            end
            if (out_valid && first_valid < 0) first_valid = c;
            out_ready = ($urandom_range(99) < ready_pct);
            abort = 1'b0;
            if (abort_after >= 0 && q_data.size() == abort_after && out_valid) begin
                abort     = 1'b1;
                out_ready = abort_ready;
            end
            if (out_valid && out_ready) begin
                q_data.push_back(int'(out_data));
                q_idx.push_back(int'(out_index));
                q_last.push_back(out_last);
            end
            step();
        end
        abort     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start_idx = '0; count = '0;
        repeat (3) step();
        n_checks++;
        if ({busy, err, out_valid, out_last, done} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {busy, err, out_valid, out_last, done});
        else n_pass++;
        n_checks++;
        if (out_data !== 32'd0 || out_index !== 2'd0 || sum !== 32'd0)
            $display("FAIL reset_data: got data=%0d idx=%0d sum=%0d expected 0/0/0", out_data, out_index, sum);
        else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if ({busy, out_valid, done} !== 3'b0)
            $display("FAIL idle_after_reset: got busy/valid/done=%b expected 000", {busy, out_valid, done});
        else n_pass++;
    endtask

    task automatic test_stream(input string name, input int idx, input int cnt, input int pct);
        int n;
        drive_cmd(idx, cnt, pct, -1, 1'b0);
        n_checks++;
        if (timed_out !== 1'b0) $display("FAIL %s timeout: busy never dropped", name);
        else n_pass++;
        n_checks++;
        if (q_data.size() !== cnt) $display("FAIL %s beats: got %0d expected %0d", name, q_data.size(), cnt);
        else n_pass++;
        n = (q_data.size() < cnt) ? q_data.size() : cnt;
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (q_data[k] !== model_data(idx, k) || q_idx[k] !== model_index(idx, k))
                $display("FAIL %s beat%0d: got data=%0d idx=%0d expected data=%0d idx=%0d",
                         name, k, q_data[k], q_idx[k], model_data(idx, k), model_index(idx, k));
            else n_pass++;
            n_checks++;
            if (q_last[k] !== (k == cnt - 1))
                $display("FAIL %s last%0d: got %0d expected %0d", name, k, q_last[k], (k == cnt - 1));
            else n_pass++;
        end
        n_checks++;
        if (first_valid !== ((cnt > 0) ? 1 : -1))
            $display("FAIL %s first_valid_cycle: got %0d expected %0d", name, first_valid, (cnt > 0) ? 1 : -1);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== idle_cyc - 1)
            $display("FAIL %s done: got %0d pulses at cycle %0d expected 1 at cycle %0d", name, done_cnt, done_cyc, idle_cyc - 1);
        else n_pass++;
        if (pct >= 100) begin
            n_checks++;
            if (done_cyc !== cnt + 1 || idle_cyc !== cnt + 2)
                $display("FAIL %s timing: got done=%0d idle=%0d expected done=%0d idle=%0d",
                         name, done_cyc, idle_cyc, cnt + 1, cnt + 2);
            else n_pass++;
        end
        n_checks++;
        if (sum !== model_sum(idx, cnt) || out_valid !== 1'b0)
            $display("FAIL %s sum: got %0d valid=%0d expected %0d valid=0", name, sum, out_valid, model_sum(idx, cnt));
        else n_pass++;
    endtask

    task automatic test_abort(input string name, input int idx, input int cnt, input int pct,
                              input int abort_after, input bit abort_ready);
        int acc;
        acc = abort_after + (abort_ready ? 1 : 0);
        drive_cmd(idx, cnt, pct, abort_after, abort_ready);
        n_checks++;
        if (timed_out !== 1'b0) $display("FAIL %s timeout: busy never dropped", name);
        else n_pass++;
        n_checks++;
        if (q_data.size() !== acc) $display("FAIL %s beats: got %0d expected %0d", name, q_data.size(), acc);
        else n_pass++;
        for (int k = 0; k < q_data.size() && k < acc; k++) begin
            n_checks++;
            if (q_data[k] !== model_data(idx, k))
                $display("FAIL %s beat%0d: got %0d expected %0d", name, k, q_data[k], model_data(idx, k));
            else n_pass++;
        end
        n_checks++;
        if (done_cnt !== 0) $display("FAIL %s done: got %0d pulses expected 0", name, done_cnt);
        else n_pass++;
        n_checks++;
        if (sum !== model_sum(idx, acc) || out_valid !== 1'b0)
            $display("FAIL %s sum: got %0d valid=%0d expected %0d valid=0", name, sum, out_valid, model_sum(idx, acc));
        else n_pass++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; start = 1'b1; start_idx = 2'd0; count = 8'd3;
        step();
        start = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd121)
            $display("FAIL bp_beat0: got valid=%0d data=%0d expected 1/121", out_valid, out_data);
        else n_pass++;
        out_ready = 1'b1;
        step();
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'd110 || out_index !== 2'd1 || out_last !== 1'b0)
                $display("FAIL bp_hold%0d: got valid=%0d data=%0d idx=%0d last=%0d expected 1/110/1/0",
                         c, out_valid, out_data, out_index, out_last);
            else n_pass++;
            out_ready = (c == 3);
            step();
        end
        n_checks++;
        if (out_data !== 32'd2 || out_last !== 1'b1)
            $display("FAIL bp_beat2: got data=%0d last=%0d expected 2/1", out_data, out_last);
        else n_pass++;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_done: got done=%0d valid=%0d expected 1/0", done, out_valid);
        else n_pass++;
        step();
        n_checks++;
        if (busy !== 1'b0 || sum !== 32'd233)
            $display("FAIL bp_sum: got busy=%0d sum=%0d expected 0/233", busy, sum);
        else n_pass++;
    endtask

    task automatic test_zero_count();
        out_ready = 1'b1; start = 1'b1; start_idx = 2'd1; count = 8'd0;
        step();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL zero_done: got done=%0d busy=%0d valid=%0d expected 1/1/0", done, busy, out_valid);
        else n_pass++;
        start_idx = 2'd0; count = 8'd4;   // start stays high through DONE
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 32'd0)
            $display("FAIL zero_idle: got busy=%0d done=%0d sum=%0d expected 0/0/0", busy, done, sum);
        else n_pass++;
        step();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL start_in_done_ignored: got busy=%0d valid=%0d expected 0/0", busy, out_valid);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_abort_idle();
        logic [31:0] prev;
        prev = sum;
        start = 1'b1; abort = 1'b1; start_idx = 2'd0; count = 8'd4;
        step();
        start = 1'b0; abort = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0 || sum !== prev)
            $display("FAIL abort_idle: got busy=%0d valid=%0d err=%0d sum=%0d expected 0/0/0/%0d",
                     busy, out_valid, err, sum, prev);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        out_ready = 1'b1; start = 1'b1; start_idx = 2'd0; count = 8'd4;
        step();
        start = 1'b0;
        step();
        step();
        n_checks++;
        if (out_data !== 32'd2) $display("FAIL midrun_third_beat: got %0d expected 2", out_data);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if ({busy, err, out_valid, out_last, done} !== 5'b0 || out_data !== 32'd0 ||
            out_index !== 2'd0 || sum !== 32'd0)
            $display("FAIL midrun_reset: got flags=%b data=%0d idx=%0d sum=%0d expected all 0",
                     {busy, err, out_valid, out_last, done}, out_data, out_index, sum);
        else n_pass++;
        test_stream("after_reset_single", 3, 1, 100);
    endtask

    task automatic test_random();
        int idx, cnt, pct, aa;
        bit ar;
        for (int i = 0; i < 12; i++) begin
            idx = $urandom_range(3);
            cnt = $urandom_range(9);
            pct = $urandom_range(100, 30);
            test_stream($sformatf("rand_stream%0d", i), idx, cnt, pct);
        end
        for (int i = 0; i < 6; i++) begin
            idx = $urandom_range(3);
            cnt = $urandom_range(9, 1);
            pct = $urandom_range(100, 40);
            aa  = $urandom_range(cnt - 1);
            ar  = 1'($urandom_range(1));
            test_abort($sformatf("rand_abort%0d", i), idx, cnt, pct, aa, ar);
        end
    endtask

    initial begin
        test_reset();
        test_stream("full_run", 0, 4, 100);
        test_stream("wrap_run", 2, 5, 100);
        test_backpressure();
        test_zero_count();
        test_abort("abort_after_first", 1, 4, 100, 1, 1'b0);
        test_abort("abort_on_final", 2, 2, 100, 1, 1'b1);
        test_abort_idle();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_table_sequencer.md
Name: param_table_sequencer

Overview:
- Sequences reads from a constant lookup table held in an unpacked-array parameter.
- Streams a contiguous, wrapping run of table entries out over a valid/ready interface.
- Accumulates a running sum of the emitted entries.
- Sits between a command source (start/index/length) and a downstream consumer. It is the controller that drives the parameter-array constant datapath.

Parameters:
- WIDTH, 32, bit width of each table entry, of out_data and of sum.
- DEPTH, 4, number of table entries.
- TABLE, '{121,110,2,20}, unpacked array [DEPTH] of WIDTH-bit constants. Entry 0 is first.
- LEN_W, 8, width of the count input.
- IDX_W, $clog2(DEPTH) (min 1), width of index signals.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  command strobe; sampled only in IDLE
- start_idx  input  IDX_W  first table index of the run
- count  input  LEN_W  number of beats to emit
- abort  input  1  cancels the run in progress
- busy  output  1  high from command acceptance until return to IDLE
- err  output  1  one-cycle pulse when a command is rejected
- out_valid  output  1  beat available
- out_ready  input  1  consumer accepts beat
- out_data  output  WIDTH  TABLE[out_index]
- out_index  output  IDX_W  current table index
- out_last  output  1  current beat is the final beat of the run
- done  output  1  one-cycle pulse after the final beat is accepted
- sum  output  WIDTH  running sum of accepted beats, modulo 2^WIDTH

Behaviour:
- Reset: state goes to IDLE. All outputs are 0 (busy, err, out_valid, out_data, out_index, out_last, done, sum). Reset overrides every other input, including in mid-run.
- States: IDLE, STREAM, DONE.
- IDLE, start=1, start_idx<DEPTH, count>0:
  - ptr<=start_idx, rem<=count, sum<=0, busy<=1.
  - Go to STREAM. out_valid rises the next cycle, i.e. one-cycle latency from start.
- IDLE, start=1, count=0: sum<=0, busy<=1, go to DONE. No beats are emitted.
- IDLE, start=1, start_idx>=DEPTH (possible only when DEPTH is not a power of two): err pulses for 1 cycle, state stays IDLE, sum is unchanged.
- STREAM outputs: out_valid=1, out_index=ptr, out_data=TABLE[ptr], out_last=(rem==1). All are registered.
- Backpressure: while out_valid & !out_ready, out_data, out_index and out_last hold stable.
- STREAM, handshake (out_valid & out_ready):
  - sum<=sum+out_data (wraps).
  - ptr<=(ptr==DEPTH-1)?0:ptr+1.
  - rem<=rem-1.
  - If rem==1, go to DONE and drop out_valid and out_last in the same edge.
- count>DEPTH is legal: the index wraps and entries repeat.
- DONE: done=1 for exactly one cycle, busy stays 1. Next cycle go to IDLE and busy=0. A start during DONE is ignored.
- start while busy (STREAM or DONE) is ignored; no err.
- abort in STREAM or DONE: next cycle is IDLE, out_valid=0, busy=0, no done pulse, sum holds its last value.
  - abort coincident with the final handshake: abort wins, no done, but sum includes that beat.
- abort in IDLE: no effect. start and abort together in IDLE: abort wins, command dropped.
- sum holds its value in IDLE until the next accepted command.

Test Plan:
- Start idx=0, count=4, out_ready=1 at cycle N -> out_valid N+1..N+4. Data 121,110,2,20, index 0..3, out_last only with 20. done at N+5, busy low at N+6, sum=253.
- Start idx=2, count=5, ready=1 -> data 2,20,121,110,2 (wrap 3->0), last on the fifth beat, sum=255.
- Start idx=0, count=3, ready low for 3 cycles while beat 2 is presented -> out_data held at 110 and out_index held at 1 for 4 cycles. Sequence then completes 121,110,2, sum=233.
- Start count=0 -> no out_valid, done at N+1, sum=0. Start pulsed again during DONE -> ignored.
- Start idx=1, count=4, abort asserted after the first handshake -> out_valid=0 next cycle, no done, sum=110, busy=0.
- Start idx=0, count=4, assert rst on the third beat -> all outputs 0 the next cycle. A new start idx=3, count=1 -> single beat 20 with out_last=1, sum=20.
